ts_pkt_sched: RTL and testbench

- Round-robin packet scheduler for the per-tuner serial-to-parallel capture channels.
- Each channel signals that a stored 188-byte packet is ready on ts_pkt_rdy and plays it out after a one-cycle ack pulse.
- This block chooses one ready channel, issues the ack, and forwards that channel's byte stream onto a single merged TS bus with a channel tag.
- It waits for end of packet, checks length and timeout, then moves to the next channel.

---
 rtl/ts_pkt_sched.sv | 170 +++++++++++++++++
 tb/tb_ts_pkt_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ts_pkt_sched.sv
// Round-robin scheduler that grants one ready tuner channel at a time, acks it,
// and forwards its packet onto a merged TS bus with channel tag and error reporting.
module ts_pkt_sched #(
  parameter int CH_NUM      = 4,
  parameter int PKT_LEN     = 188,
  parameter int SOP_TIMEOUT = 15,
  parameter int EOP_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH_NUM-1:0]     ts_pkt_rdy,
  output logic [CH_NUM-1:0]     ts_pkt_ack,
  input  logic [8*CH_NUM-1:0]   ts_i_data,
  input  logic [CH_NUM-1:0]     ts_i_valid,
  input  logic [CH_NUM-1:0]     ts_i_sop,
  input  logic [CH_NUM-1:0]     ts_i_eop,
  input  logic                  out_rdy,
  output logic [7:0]            ts_o_data,
  output logic                  ts_o_valid,
  output logic                  ts_o_sop,
  output logic                  ts_o_eop,
  output logic [1:0]            ts_o_ch,
  output logic                  err_pulse,
  output logic [1:0]            err_code,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACK      = 3'd1,
    WAIT_SOP = 3'd2,
    XFER     = 3'd3,
    GAP      = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] sel, last_ch, grant;
  logic       grant_vld;
  logic [7:0] timer, byte_cnt, cnt_inc;
  logic       sel_valid, sel_sop, sel_eop, sop_hit;
  logic [7:0] sel_data;
  logic       take_grant, timer_clr, fwd, marker, err_set;
  logic [1:0] err_val;

  assign state_dbg = state;
  assign sel_valid = ts_i_valid[sel];
  assign sel_sop   = ts_i_sop[sel];
  assign sel_eop   = ts_i_eop[sel];
  assign sel_data  = ts_i_data[8*int'(sel) +: 8];
  assign sop_hit   = sel_valid & sel_sop;
  assign cnt_inc   = (byte_cnt == 8'hFF) ? 8'hFF : byte_cnt + 8'd1;

  // Scan downward so the nearest ready channel above last_ch wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = last_ch;
    for (int i = CH_NUM; i >= 1; i--) begin
      if (ts_pkt_rdy[2'((int'(last_ch) + i) % CH_NUM)]) begin
        grant_vld = 1'b1;
        grant     = 2'((int'(last_ch) + i) % CH_NUM);
      end
    end
  end

  // Timeouts fire one cycle early so the registered err_pulse lands exactly
  // SOP_TIMEOUT cycles after the ack (EOP_TIMEOUT cycles after the sop).
  always_comb begin
    state_nxt  = state;
    ts_pkt_ack = '0;
    take_grant = 1'b0;
    timer_clr  = 1'b0;
    fwd        = 1'b0;
    marker     = 1'b0;
    err_set    = 1'b0;
    err_val    = 2'b00;
    case (state)
      IDLE: begin
        if (out_rdy && grant_vld) begin
          take_grant = 1'b1;
          state_nxt  = ACK;
        end
      end
      ACK: begin
        ts_pkt_ack[sel] = 1'b1;
        timer_clr       = 1'b1;
        state_nxt       = WAIT_SOP;
      end
      WAIT_SOP: begin
        if (sop_hit) begin
          fwd       = 1'b1;
          timer_clr = 1'b1;
          if (sel_eop) begin
            state_nxt = GAP;
            if (8'd1 != 8'(PKT_LEN)) begin
              err_set = 1'b1;
              err_val = 2'b11;
            end
          end else begin
            state_nxt = XFER;
          end
        end else if (timer == 8'(SOP_TIMEOUT - 2)) begin
          err_set   = 1'b1;
          err_val   = 2'b01;
          state_nxt = GAP;
        end
      end
      XFER: begin
        if (sel_valid && sel_eop) begin
          fwd       = 1'b1;
          state_nxt = GAP;
          if (cnt_inc != 8'(PKT_LEN)) begin
            err_set = 1'b1;
            err_val = 2'b11;
          end
        end else if (timer == 8'(EOP_TIMEOUT - 2)) begin
          marker    = 1'b1;
          err_set   = 1'b1;
          err_val   = 2'b10;
          state_nxt = GAP;
        end else begin
          fwd = 1'b1;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sel      <= '0;
      last_ch  <= 2'(CH_NUM - 1);
      timer    <= '0;
      byte_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (take_grant) begin
        sel     <= grant;
        last_ch <= grant;
      end
      if (timer_clr) timer <= '0;
      else if (state == WAIT_SOP || state == XFER) timer <= timer + 8'd1;
      if (state == WAIT_SOP && sop_hit) byte_cnt <= 8'd1;
      else if (state == XFER && sel_valid) byte_cnt <= cnt_inc;
    end
  end

  // Registered forwarding mux; the eop-timeout marker carries eop without valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_o_data  <= '0;
      ts_o_valid <= 1'b0;
      ts_o_sop   <= 1'b0;
      ts_o_eop   <= 1'b0;
      ts_o_ch    <= '0;
      err_pulse  <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      ts_o_valid <= fwd & sel_valid;
      ts_o_data  <= (fwd & sel_valid) ? sel_data : 8'h00;
      ts_o_sop   <= fwd & sel_valid & sel_sop;
      ts_o_eop   <= (fwd & sel_valid & sel_eop) | marker;
      ts_o_ch    <= sel;
      err_pulse  <= err_set;
      if (err_set) err_code <= err_val;
    end
  end

endmodule

// File: tb/tb_ts_pkt_sched.sv
// Directed bench for ts_pkt_sched: round robin, single packet, sop/eop timeouts,
// length error, packet-level backpressure and mid-packet reset.
module tb_ts_pkt_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ts_pkt_rdy;
  logic [3:0]  ts_pkt_ack;
  logic [31:0] ts_i_data;
  logic [3:0]  ts_i_valid, ts_i_sop, ts_i_eop;
  logic        out_rdy;
  logic [7:0]  ts_o_data;
  logic        ts_o_valid, ts_o_sop, ts_o_eop;
  logic [1:0]  ts_o_ch;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic [2:0]  state_dbg;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GAP  = 3'd4;

  ts_pkt_sched dut (
    .clk(clk), .rst(rst),
    .ts_pkt_rdy(ts_pkt_rdy), .ts_pkt_ack(ts_pkt_ack),
    .ts_i_data(ts_i_data), .ts_i_valid(ts_i_valid),
    .ts_i_sop(ts_i_sop), .ts_i_eop(ts_i_eop),
    .out_rdy(out_rdy),
    .ts_o_data(ts_o_data), .ts_o_valid(ts_o_valid),
    .ts_o_sop(ts_o_sop), .ts_o_eop(ts_o_eop), .ts_o_ch(ts_o_ch),
    .err_pulse(err_pulse), .err_code(err_code), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] pack_out();
    return {ts_o_valid, ts_o_sop, ts_o_eop, ts_o_ch, ts_o_data};
  endfunction

  // driver tasks: other lanes carry random noise the scheduler must ignore
  task automatic drive_byte(input int ch, input logic [7:0] d, input logic sop, input logic eop);
    ts_i_valid = 4'($urandom_range(0, 15));
    ts_i_sop   = 4'($urandom_range(0, 15));
    ts_i_eop   = 4'($urandom_range(0, 15));
    ts_i_data  = $urandom();
    ts_i_valid[ch]         = 1'b1;
    ts_i_sop[ch]           = sop;
    ts_i_eop[ch]           = eop;
    ts_i_data[8*ch +: 8]   = d;
  endtask

  task automatic drive_idle();
    ts_i_valid = '0;
    ts_i_sop   = '0;
    ts_i_eop   = '0;
    ts_i_data  = '0;
  endtask

  task automatic wait_ack(input int ch, input int max_cyc, input int exp_n);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (ts_pkt_ack == 4'b0000 && n < max_cyc);
    chk("ack_onehot", 32'(ts_pkt_ack), 32'(4'b0001 << ch));
    if (exp_n > 0) chk("ack_latency", n, exp_n);
  endtask

  // Called in the ack cycle; plays a packet out and checks every forwarded byte.
  task automatic send_pkt(input int ch, input int len, input logic [7:0] b0,
                          input int drop_at, input logic exp_ep, input logic [1:0] exp_ec);
    logic [7:0] d;
    for (int i = 0; i <= len; i++) begin
      tick();
      if (i == 0) begin
        chk("ack_one_cycle", 32'(ts_pkt_ack), 32'd0);
      end else begin
        d = b0 + 8'(i - 1);
        chk("fwd_byte", 32'(pack_out()), 32'({1'b1, (i == 1), (i == len), 2'(ch), d}));
      end
      if (i == len) begin
        chk("pkt_err", {28'd0, err_pulse, err_code, 1'b0}, {28'd0, exp_ep, exp_ec, 1'b0});
        chk("pkt_gap_state", 32'(state_dbg), 32'(S_GAP));
      end
      if (i == drop_at) out_rdy = 1'b0;
      if (i < len) drive_byte(ch, b0 + 8'(i), (i == 0), (i == len - 1));
      else drive_idle();
    end
  endtask

  initial begin
    rst        = 1'b0;
    ts_pkt_rdy = '0;
    out_rdy    = 1'b0;
    drive_idle();
    #2;
    chk("reset_outputs", 32'({pack_out(), err_pulse, err_code, ts_pkt_ack, state_dbg}), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;

    // round robin: all channels ready, grants 0,1,2,3,0 with a GAP between packets
    ts_pkt_rdy = 4'b1111;
    out_rdy    = 1'b1;
    wait_ack(0, 4, 1);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) ts_pkt_rdy = 4'b0000;
      send_pkt(k % 4, 188, 8'(8'h10 * k), -1, 1'b0, 2'b00);
      if (k < 4) wait_ack((k + 1) % 4, 4, 2);
    end

    // single packet on ch2 starting at 0x42
    ts_pkt_rdy = 4'b0100;
    wait_ack(2, 4, 2);
    ts_pkt_rdy = 4'b0000;
    send_pkt(2, 188, 8'h42, -1, 1'b0, 2'b00);

    // sop timeout on ch1; non-sop bytes must be dropped
    ts_pkt_rdy = 4'b0010;
    wait_ack(1, 4, 2);
    ts_pkt_rdy = 4'b0000;
    for (int k = 1; k <= 15; k++) begin
      tick();
      drive_byte(1, 8'(k), 1'b0, 1'b0);
      if (k < 15) begin
        chk("sop_to_quiet", {30'd0, err_pulse, ts_o_valid}, 32'd0);
      end else begin
        chk("sop_to_err", {27'd0, err_pulse, err_code, ts_o_valid, ts_o_eop}, {27'd0, 1'b1, 2'b01, 2'b00});
        chk("sop_to_gap", 32'(state_dbg), 32'(S_GAP));
      end
    end
    tick();
    drive_idle();
    chk("sop_to_idle", {27'd0, state_dbg, err_pulse, ts_o_valid}, {27'd0, S_IDLE, 2'b00});

    // length error: ch3 ends on byte 100
    ts_pkt_rdy = 4'b1000;
    wait_ack(3, 4, 1);
    ts_pkt_rdy = 4'b0000;
    send_pkt(3, 100, 8'h00, -1, 1'b1, 2'b11);

    // backpressure: no grant while out_rdy low; drop out_rdy mid-packet
    out_rdy    = 1'b0;
    ts_pkt_rdy = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_no_ack", {25'd0, ts_pkt_ack, state_dbg}, {25'd0, 4'b0000, S_IDLE});
    end
    out_rdy = 1'b1;
    wait_ack(0, 2, 1);
    ts_pkt_rdy = 4'b0000;
    send_pkt(0, 188, 8'hA0, 60, 1'b0, 2'b11);
    out_rdy = 1'b1;

    // eop timeout on ch1: sop only, then a valid-less eop marker 255 cycles on
    ts_pkt_rdy = 4'b0010;
    wait_ack(1, 4, 2);
    ts_pkt_rdy = 4'b0000;
    tick();
    drive_byte(1, 8'h5A, 1'b1, 1'b0);
    tick();
    drive_idle();
    chk("eop_to_sop", 32'(pack_out()), 32'({1'b1, 1'b1, 1'b0, 2'd1, 8'h5A}));
    for (int k = 2; k <= 255; k++) begin
      tick();
      if (k < 255) begin
        chk("eop_to_quiet", {29'd0, ts_o_valid, ts_o_eop, err_pulse}, 32'd0);
      end else begin
        chk("eop_to_marker", {27'd0, ts_o_valid, ts_o_eop, err_pulse, err_code}, {27'd0, 1'b0, 1'b1, 1'b1, 2'b10});
        chk("eop_to_gap", 32'(state_dbg), 32'(S_GAP));
      end
    end

    // reset mid-XFER at byte 50, then ch0 wins over ch1
    ts_pkt_rdy = 4'b0001;
    wait_ack(0, 4, 2);
    ts_pkt_rdy = 4'b0000;
    for (int i = 0; i < 50; i++) begin
      tick();
      drive_byte(0, 8'(i), (i == 0), 1'b0);
    end
    tick();
    chk("pre_reset_byte", 32'(pack_out()), 32'({1'b1, 1'b0, 1'b0, 2'd0, 8'd49}));
    rst = 1'b0;
    #1;
    chk("mid_reset_outputs", 32'({pack_out(), err_pulse, err_code, ts_pkt_ack, state_dbg}), 32'd0);
    drive_idle();
    tick();
    tick();
    #2 rst = 1'b1;
    ts_pkt_rdy = 4'b0011;
    wait_ack(0, 4, 1);
    ts_pkt_rdy = 4'b0000;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
